pong_game_ctrl: RTL and testbench
=================================

Name: pong_game_ctrl

Overview:
- Game sequencer for the FPGA Pong design.
- Owns all game state: ball position and direction, both paddle positions, scores, serve and game-over phases.
- Advances once per video frame on a frame_tick strobe from the VGA timing block.
- Exposes coordinates in active-area pixels (0..639, 0..479). The VGA renderer adds the porch offsets and draws the objects.

Parameters:
BALL_SIZE, 8, ball edge length in pixels (square)
BALL_STEP, 2, ball x and y displacement per frame
PAD_H, 100, paddle height in pixels
PAD_STEP, 4, paddle displacement per frame while a button is held
WIN_SCORE, 9, score that ends the game
SERVE_FRAMES, 60, frames the ball is held at centre before play

Ports:
dclk  in  1  25 MHz pixel clock
clr_n  in  1  reset; synchronous, active-low
frame_tick  in  1  one-cycle pulse per frame, at the start of vsync
start  in  1  one-cycle pulse; starts the game or restarts it after game over
btn_up_l, btn_dn_l  in  1 each  left paddle controls, already debounced and synchronised
btn_up_r, btn_dn_r  in  1 each  right paddle controls, already debounced and synchronised
ball_x, ball_y  out  10 each  top-left corner of the ball
pad_l_y, pad_r_y  out  10 each  top edge of each paddle
score_l, score_r  out  4 each  scores, 0..WIN_SCORE
game_state  out  3  current FSM state encoding
point_pulse  out  1  one-cycle pulse when a point is scored
game_over  out  1  high while in the OVER state

Behaviour:
- Field constants (package):
  - Inner playfield: x 50..589, y 50..429.
  - Left paddle face at x=70 (paddle occupies x 55..69).
  - Right paddle face at x=570 (paddle occupies x 570..584).
  - Paddle y range: 50..330.
  - Ball centre serve position: (316, 236).
- Reset (clr_n=0 sampled at a dclk edge), overriding all other inputs:
  - state IDLE; ball_x=316, ball_y=236; pad_l_y=pad_r_y=190.
  - Scores 0; direction dx=+1, dy=+1.
  - point_pulse=0, game_over=0.
- Timing:
  - All updates are registered and happen only on cycles where frame_tick=1.
  - Outputs reflect the new values on the next cycle (latency 1).
  - Outputs are stable for the rest of the frame.
- FSM transitions:
  - IDLE: start → SERVE. frame_tick is ignored. If start and frame_tick arrive in the same cycle, start wins and no motion occurs.
  - SERVE:
    - Ball is held at centre; the serve counter is cleared on entry.
    - Paddles still move.
    - Each tick increments the counter; when the counter reaches SERVE_FRAMES-1 on a tick → PLAY.
  - PLAY, on each tick:
    - Paddle update, then ball update.
    - The ball overlap check uses the pre-update paddle position.
  - POINT: lasts exactly one cycle.
    - Increments the scorer's score and pulses point_pulse.
    - If the new score equals WIN_SCORE → OVER; else → SERVE.
    - New dx points toward the player who lost the point; dy is inverted relative to the previous serve.
  - OVER: game_over=1; all motion frozen. start → scores cleared, paddles reset to 190, → SERVE.
- Paddle update:
  - up alone: y−PAD_STEP; down alone: y+PAD_STEP; both or neither: hold.
  - Result is clamped to 50..330. There is no wrap-around; compute in 11 bits before clamping.
- Ball update:
  - Next position: nx = x ± BALL_STEP, ny = y ± BALL_STEP, computed in 11-bit signed arithmetic.
  - Top wall: dy<0 and ny ≤ 50 → y=50, dy=+.
  - Bottom wall: dy>0 and ny+BALL_SIZE ≥ 430 → y=430−BALL_SIZE, dy=−.
  - Left paddle: dx<0, nx ≤ 70, and vertical overlap (ny+BALL_SIZE > pad_l_y and ny < pad_l_y+PAD_H) → x=70, dx=+.
  - Right paddle: dx>0, nx+BALL_SIZE ≥ 570, and overlap → x=570−BALL_SIZE, dx=−.
  - Miss left (dx<0, nx ≤ 70, no overlap): ball continues. When nx ≤ 50 → right scores, → POINT.
  - Miss right (dx>0, nx+BALL_SIZE ≥ 570, no overlap): ball continues. When nx+BALL_SIZE ≥ 590 → left scores, → POINT.
  - Wall and paddle reflections on the same tick (corner hit): both apply.
  - A miss takes priority over a wall bounce on the same tick for the state transition; the y clamp still applies.
- Scores saturate at WIN_SCORE and never wrap.
- start while in PLAY or SERVE is ignored.

Decomposition:
- Package pong_pkg holds:
  - State enum: IDLE, SERVE, PLAY, POINT, OVER.
  - Field and paddle-face constants.
  - Serve centre coordinates.
  - Coordinate width (10).
- Sub-module pong_paddle is instantiated twice. It contains the clamped position register with reset value, step, and up/down inputs.

Test Plan:
1. Reset, start, 60 ticks → game_state=PLAY on the cycle after the 60th tick. The next tick gives ball_x=318, ball_y=238.
2. Hold btn_up_l for 40 ticks from pad_l_y=190 → pad_l_y=50 and it stays 50. Press both buttons → no change.
3. Force ball to y=52 with dy<0 and tick → ball_y=50, dy becomes +. The next tick gives ball_y=52.
4. Left paddle at 190, ball at (72, 200) with dx<0, tick → ball_x=70, dx=+. Repeat with paddle at 50 → ball passes; right scores, point_pulse for one cycle, score_r=1, ball re-centred.
5. Drive score_l to 8 and score one more → score_l=9, game_over=1, ball frozen across 10 ticks. start → scores 0, state SERVE.
6. Assert clr_n=0 for one cycle mid-PLAY together with frame_tick → all outputs at reset values on the next cycle, state IDLE.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared playfield geometry, state encoding and coordinate width for the Pong game sequencer.
package pong_pkg;

    localparam int COORD_W = 10;

    // Inner playfield bounds in active-area pixels (inclusive).
    localparam int FIELD_X_MIN = 50;
    localparam int FIELD_X_MAX = 589;
    localparam int FIELD_Y_MIN = 50;
    localparam int FIELD_Y_MAX = 429;

    localparam int PAD_L_FACE  = 70;
    localparam int PAD_R_FACE  = 570;
    localparam int PAD_Y_MIN   = 50;
    localparam int PAD_Y_MAX   = 330;
    localparam int PAD_Y_RESET = 190;

    localparam int SERVE_X = 316;
    localparam int SERVE_Y = 236;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } game_state_e;

endpackage

// File: rtl/pong_paddle.sv
// One paddle: vertical position register that steps on enable and clamps to the paddle travel range.
module pong_paddle
    import pong_pkg::*;
#(
    parameter int STEP    = 4,
    parameter int RESET_Y = PAD_Y_RESET,
    parameter int Y_MIN   = PAD_Y_MIN,
    parameter int Y_MAX   = PAD_Y_MAX
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               en_i,
    input  logic               load_i,
    input  logic               up_i,
    input  logic               dn_i,
    output logic [COORD_W-1:0] y_o
);

    localparam int WW = COORD_W + 1;

    logic [COORD_W-1:0] y_q, y_d;
    logic [WW-1:0]      y_wide;

    // One extra bit keeps y-STEP below Y_MIN from wrapping before the clamp.
    always_comb begin
        y_wide = {1'b0, y_q};
        if (up_i && !dn_i) begin
            y_wide = {1'b0, y_q} - WW'(STEP);
        end else if (dn_i && !up_i) begin
            y_wide = {1'b0, y_q} + WW'(STEP);
        end
        if (y_wide < WW'(Y_MIN)) begin
            y_wide = WW'(Y_MIN);
        end else if (y_wide > WW'(Y_MAX)) begin
            y_wide = WW'(Y_MAX);
        end

        y_d = y_q;
        if (load_i) begin
            y_d = COORD_W'(RESET_Y);
        end else if (en_i) begin
            y_d = COORD_W'(y_wide);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            y_q <= COORD_W'(RESET_Y);
        end else begin
            y_q <= y_d;
        end
    end

    assign y_o = y_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve/play/point/over phases, ball motion and scoring, advanced once per frame_tick.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int BALL_SIZE    = 8,
    parameter int BALL_STEP    = 2,
    parameter int PAD_H        = 100,
    parameter int PAD_STEP     = 4,
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 60
) (
    input  logic               dclk,
    input  logic               clr_n,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               btn_up_l,
    input  logic               btn_dn_l,
    input  logic               btn_up_r,
    input  logic               btn_dn_r,
    output logic [COORD_W-1:0] ball_x,
    output logic [COORD_W-1:0] ball_y,
    output logic [COORD_W-1:0] pad_l_y,
    output logic [COORD_W-1:0] pad_r_y,
    output logic [3:0]         score_l,
    output logic [3:0]         score_r,
    output logic [2:0]         game_state,
    output logic               point_pulse,
    output logic               game_over
);

    localparam int SW    = COORD_W + 1;
    localparam int CNT_W = $clog2(SERVE_FRAMES);
    typedef logic signed [SW-1:0] scoord_t;

    localparam scoord_t K_STEP  = scoord_t'(BALL_STEP);
    localparam scoord_t K_SIZE  = scoord_t'(BALL_SIZE);
    localparam scoord_t K_PAD_H = scoord_t'(PAD_H);
    localparam scoord_t K_TOP   = scoord_t'(FIELD_Y_MIN);
    localparam scoord_t K_BOT   = scoord_t'(FIELD_Y_MAX + 1);
    localparam scoord_t K_LFACE = scoord_t'(PAD_L_FACE);
    localparam scoord_t K_RFACE = scoord_t'(PAD_R_FACE);
    localparam scoord_t K_LGOAL = scoord_t'(FIELD_X_MIN);
    localparam scoord_t K_RGOAL = scoord_t'(FIELD_X_MAX + 1);
    localparam logic [3:0] K_WIN = 4'(WIN_SCORE);

    game_state_e        state_q, state_d;
    logic [COORD_W-1:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic               dx_q, dx_d, dy_q, dy_d, serve_dy_q, serve_dy_d;
    logic               scorer_l_q, scorer_l_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         score_l_q, score_l_d, score_r_q, score_r_d;
    logic               pad_en, pad_load;

    scoord_t bx, by, nx, ny, pl, pr, bx_nxt, by_nxt;
    logic    dx_nxt, dy_nxt, ov_l, ov_r, left_scores, right_scores;
    logic [3:0] sl_inc, sr_inc;
    logic    point_won;

    // Candidate ball motion for this frame; dx/dy high means moving right/down.
    always_comb begin
        bx = scoord_t'({1'b0, ball_x_q});
        by = scoord_t'({1'b0, ball_y_q});
        pl = scoord_t'({1'b0, pad_l_y});
        pr = scoord_t'({1'b0, pad_r_y});
        nx = dx_q ? bx + K_STEP : bx - K_STEP;
        ny = dy_q ? by + K_STEP : by - K_STEP;
        ov_l = (ny + K_SIZE > pl) && (ny < pl + K_PAD_H);
        ov_r = (ny + K_SIZE > pr) && (ny < pr + K_PAD_H);

        by_nxt = ny;
        dy_nxt = dy_q;
        if (!dy_q && ny <= K_TOP) begin
            by_nxt = K_TOP;
            dy_nxt = 1'b1;
        end else if (dy_q && ny + K_SIZE >= K_BOT) begin
            by_nxt = K_BOT - K_SIZE;
            dy_nxt = 1'b0;
        end

        bx_nxt       = nx;
        dx_nxt       = dx_q;
        left_scores  = 1'b0;
        right_scores = 1'b0;
        if (!dx_q && nx <= K_LFACE) begin
            if (ov_l) begin
                bx_nxt = K_LFACE;
                dx_nxt = 1'b1;
            end else begin
                right_scores = (nx <= K_LGOAL);
            end
        end else if (dx_q && nx + K_SIZE >= K_RFACE) begin
            if (ov_r) begin
                bx_nxt = K_RFACE - K_SIZE;
                dx_nxt = 1'b0;
            end else begin
                left_scores = (nx + K_SIZE >= K_RGOAL);
            end
        end
    end

    assign sl_inc    = (score_l_q < K_WIN) ? score_l_q + 4'd1 : score_l_q;
    assign sr_inc    = (score_r_q < K_WIN) ? score_r_q + 4'd1 : score_r_q;
    assign point_won = scorer_l_q ? (sl_inc == K_WIN) : (sr_inc == K_WIN);

    always_comb begin
        state_d    = state_q;
        ball_x_d   = ball_x_q;
        ball_y_d   = ball_y_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        serve_dy_d = serve_dy_q;
        scorer_l_d = scorer_l_q;
        cnt_d      = cnt_q;
        score_l_d  = score_l_q;
        score_r_d  = score_r_q;
        pad_en     = 1'b0;
        pad_load   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SERVE;
                    cnt_d   = '0;
                end
            end
            ST_SERVE: begin
                if (frame_tick) begin
                    pad_en = 1'b1;
                    if (cnt_q == CNT_W'(SERVE_FRAMES - 1)) begin
                        state_d = ST_PLAY;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_PLAY: begin
                if (frame_tick) begin
                    pad_en   = 1'b1;
                    ball_x_d = COORD_W'(bx_nxt);
                    ball_y_d = COORD_W'(by_nxt);
                    dx_d     = dx_nxt;
                    dy_d     = dy_nxt;
                    if (left_scores || right_scores) begin
                        state_d    = ST_POINT;
                        scorer_l_d = left_scores;
                    end
                end
            end
            ST_POINT: begin
                if (scorer_l_q) begin
                    score_l_d = sl_inc;
                end else begin
                    score_r_d = sr_inc;
                end
                state_d    = point_won ? ST_OVER : ST_SERVE;
                cnt_d      = '0;
                ball_x_d   = COORD_W'(SERVE_X);
                ball_y_d   = COORD_W'(SERVE_Y);
                // Serve toward the player who just lost the point.
                dx_d       = scorer_l_q;
                dy_d       = ~serve_dy_q;
                serve_dy_d = ~serve_dy_q;
            end
            ST_OVER: begin
                if (start) begin
                    state_d   = ST_SERVE;
                    cnt_d     = '0;
                    score_l_d = '0;
                    score_r_d = '0;
                    pad_load  = 1'b1;
                    ball_x_d  = COORD_W'(SERVE_X);
                    ball_y_d  = COORD_W'(SERVE_Y);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge dclk) begin
        if (!clr_n) begin
            state_q    <= ST_IDLE;
            ball_x_q   <= COORD_W'(SERVE_X);
            ball_y_q   <= COORD_W'(SERVE_Y);
            dx_q       <= 1'b1;
            dy_q       <= 1'b1;
            serve_dy_q <= 1'b1;
            scorer_l_q <= 1'b0;
            cnt_q      <= '0;
            score_l_q  <= '0;
            score_r_q  <= '0;
        end else begin
            state_q    <= state_d;
            ball_x_q   <= ball_x_d;
            ball_y_q   <= ball_y_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            serve_dy_q <= serve_dy_d;
            scorer_l_q <= scorer_l_d;
            cnt_q      <= cnt_d;
            score_l_q  <= score_l_d;
            score_r_q  <= score_r_d;
        end
    end

    pong_paddle #(.STEP(PAD_STEP)) u_pad_l (
        .clk_i   (dclk),
        .rst_n_i (clr_n),
        .en_i    (pad_en),
        .load_i  (pad_load),
        .up_i    (btn_up_l),
        .dn_i    (btn_dn_l),
        .y_o     (pad_l_y)
    );

    pong_paddle #(.STEP(PAD_STEP)) u_pad_r (
        .clk_i   (dclk),
        .rst_n_i (clr_n),
        .en_i    (pad_en),
        .load_i  (pad_load),
        .up_i    (btn_up_r),
        .dn_i    (btn_dn_r),
        .y_o     (pad_r_y)
    );

    assign ball_x      = ball_x_q;
    assign ball_y      = ball_y_q;
    assign score_l     = score_l_q;
    assign score_r     = score_r_q;
    assign game_state  = state_q;
    assign point_pulse = (state_q == ST_POINT);
    assign game_over   = (state_q == ST_OVER);

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Randomised bench for pong_game_ctrl: a frame-level game model predicts every cycle's outputs into a scoreboard queue.
module tb_pong_game_ctrl;
    import pong_pkg::*;

    logic       dclk, clr_n, frame_tick, start;
    logic       btn_up_l, btn_dn_l, btn_up_r, btn_dn_r;
    logic [9:0] ball_x, ball_y, pad_l_y, pad_r_y;
    logic [3:0] score_l, score_r;
    logic [2:0] game_state;
    logic       point_pulse, game_over;

    pong_game_ctrl dut (
        .dclk        (dclk),
        .clr_n       (clr_n),
        .frame_tick  (frame_tick),
        .start       (start),
        .btn_up_l    (btn_up_l),
        .btn_dn_l    (btn_dn_l),
        .btn_up_r    (btn_up_r),
        .btn_dn_r    (btn_dn_r),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .pad_l_y     (pad_l_y),
        .pad_r_y     (pad_r_y),
        .score_l     (score_l),
        .score_r     (score_r),
        .game_state  (game_state),
        .point_pulse (point_pulse),
        .game_over   (game_over)
    );

    // Clock and reset
    initial dclk = 1'b0;
    always #5 dclk = ~dclk;

    int n_compared   = 0;
    int n_mismatched = 0;
    logic [52:0] exp_q[$];

    // Reference model: whole-frame game rules on plain integers.
    game_state_e m_st;
    int m_bx, m_by, m_dx, m_dy, m_pl, m_pr, m_sl, m_sr, m_ticks, m_serve_dy;
    bit m_left_scored;

    function automatic int pad_move(input int y, input logic up, input logic dn);
        int v;
        v = y;
        if (up && !dn) v = y - 4;
        else if (dn && !up) v = y + 4;
        if (v < 50) v = 50;
        if (v > 330) v = 330;
        return v;
    endfunction

    function automatic bit overlaps(input int ny, input int pad);
        return (ny + 8 > pad) && (ny < pad + 100);
    endfunction

    task automatic model_centre();
        m_bx    = 316;
        m_by    = 236;
        m_ticks = 0;
    endtask

    task automatic model_play_frame();
        int nx, ny;
        nx = m_bx + 2 * m_dx;
        ny = m_by + 2 * m_dy;
        if (m_dy < 0 && ny <= 50) begin
            m_by = 50; m_dy = 1;
        end else if (m_dy > 0 && ny + 8 >= 430) begin
            m_by = 422; m_dy = -1;
        end else begin
            m_by = ny;
        end
        m_bx = nx;
        if (m_dx < 0 && nx <= 70) begin
            if (overlaps(ny, m_pl)) begin
                m_bx = 70; m_dx = 1;
            end else if (nx <= 50) begin
                m_st = ST_POINT; m_left_scored = 1'b0;
            end
        end else if (m_dx > 0 && nx + 8 >= 570) begin
            if (overlaps(ny, m_pr)) begin
                m_bx = 562; m_dx = -1;
            end else if (nx + 8 >= 590) begin
                m_st = ST_POINT; m_left_scored = 1'b1;
            end
        end
        m_pl = pad_move(m_pl, btn_up_l, btn_dn_l);
        m_pr = pad_move(m_pr, btn_up_r, btn_dn_r);
    endtask

    task automatic model_step();
        if (!clr_n) begin
            m_st = ST_IDLE; model_centre();
            m_pl = 190; m_pr = 190; m_sl = 0; m_sr = 0;
            m_dx = 1; m_dy = 1; m_serve_dy = 1; m_left_scored = 1'b0;
        end else begin
            case (m_st)
                ST_IDLE: if (start) begin m_st = ST_SERVE; model_centre(); end
                ST_SERVE: if (frame_tick) begin
                    m_pl = pad_move(m_pl, btn_up_l, btn_dn_l);
                    m_pr = pad_move(m_pr, btn_up_r, btn_dn_r);
                    m_ticks++;
                    if (m_ticks == 60) m_st = ST_PLAY;
                end
                ST_PLAY: if (frame_tick) model_play_frame();
                ST_POINT: begin
                    if (m_left_scored) m_sl = (m_sl < 9) ? m_sl + 1 : 9;
                    else               m_sr = (m_sr < 9) ? m_sr + 1 : 9;
                    m_st = (m_sl == 9 || m_sr == 9) ? ST_OVER : ST_SERVE;
                    model_centre();
                    m_dx = m_left_scored ? 1 : -1;
                    m_serve_dy = -m_serve_dy;
                    m_dy = m_serve_dy;
                end
                ST_OVER: if (start) begin
                    m_st = ST_SERVE; model_centre();
                    m_sl = 0; m_sr = 0; m_pl = 190; m_pr = 190;
                end
                default: m_st = ST_IDLE;
            endcase
        end
    endtask

    function automatic logic [52:0] model_pack();
        return {10'(m_bx), 10'(m_by), 10'(m_pl), 10'(m_pr), 4'(m_sl), 4'(m_sr),
                3'(m_st), (m_st == ST_POINT), (m_st == ST_OVER)};
    endfunction

    always @(posedge dclk) begin
        model_step();
        exp_q.push_back(model_pack());
    end

    // Scoreboard monitor: one expected snapshot per clock edge.
    logic [52:0] exp_v, got_v;
    always @(negedge dclk) begin
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            got_v = {ball_x, ball_y, pad_l_y, pad_r_y, score_l, score_r, game_state, point_pulse, game_over};
            n_compared++;
            if (got_v !== exp_v) begin
                n_mismatched++;
                $display("FAIL outputs t=%0t got bx=%0d by=%0d pl=%0d pr=%0d sl=%0d sr=%0d st=%0d pp=%0b go=%0b required bx=%0d by=%0d pl=%0d pr=%0d sl=%0d sr=%0d st=%0d pp=%0b go=%0b",
                         $time, got_v[52:43], got_v[42:33], got_v[32:23], got_v[22:13], got_v[12:9], got_v[8:5], got_v[4:2], got_v[1], got_v[0],
                         exp_v[52:43], exp_v[42:33], exp_v[32:23], exp_v[22:13], exp_v[12:9], exp_v[8:5], exp_v[4:2], exp_v[1], exp_v[0]);
            end
        end
    end

    // Driver tasks
    task automatic drive(input logic t, input logic s, input logic ul, input logic dl,
                         input logic ur, input logic dr, input logic rn);
        frame_tick = t; start = s;
        btn_up_l = ul; btn_dn_l = dl; btn_up_r = ur; btn_dn_r = dr;
        clr_n = rn;
        @(posedge dclk);
        #1;
    endtask

    int mode_l, mode_r;

    task automatic pick_btn(input int mode, input int pad, output logic up, output logic dn);
        case (mode)
            0: begin up = 1'($urandom_range(0, 1)); dn = 1'($urandom_range(0, 1)); end
            1: begin up = (m_by + 4 < pad + 42); dn = (m_by + 4 > pad + 58); end
            2: begin up = 1'b0; dn = 1'b0; end
            default: begin up = 1'b1; dn = 1'b1; end
        endcase
    endtask

    task automatic random_cycle();
        logic t, s, ul, dl, ur, dr;
        if ($urandom_range(0, 149) == 0) mode_l = $urandom_range(0, 3);
        if ($urandom_range(0, 149) == 0) mode_r = $urandom_range(0, 3);
        t = ($urandom_range(0, 3) != 0);
        s = ($urandom_range(0, 199) == 0);
        pick_btn(mode_l, m_pl, ul, dl);
        pick_btn(mode_r, m_pr, ur, dr);
        drive(t, s, ul, dl, ur, dr, 1'b1);
    endtask

    initial begin
        mode_l = 0;
        mode_r = 0;
        repeat (3) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        // IDLE ignores ticks and buttons.
        repeat (5) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        // start together with a tick: start wins.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        // Whole serve with left held up and right held down: both clamp.
        repeat (60) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (4) drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

        for (int c = 0; c < 60000 && m_st != ST_OVER; c++) random_cycle();
        if (m_st != ST_OVER) begin
            n_mismatched++;
            $display("FAIL over_timeout state=%0d required=%0d", m_st, ST_OVER);
        end

        // Frozen in OVER despite ticks and buttons.
        repeat (12) drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

        for (int c = 0; c < 2000 && m_st != ST_PLAY; c++) random_cycle();
        if (m_st != ST_PLAY) begin
            n_mismatched++;
            $display("FAIL play_timeout state=%0d required=%0d", m_st, ST_PLAY);
        end
        repeat (30) random_cycle();

        // Reset mid-play coinciding with a frame tick.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (6) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

        @(negedge dclk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
